// File: rtl/dmem_pkg.sv
// Shared constants, types and the address decoder for the data-memory responder.
package dmem_pkg;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned ST_W   = 2;

   // I/O register offsets inside the 16-byte window
   localparam logic [3:0] IO_CYCLE  = 4'h0;
   localparam logic [3:0] IO_OUT    = 4'h4;
   localparam logic [3:0] IO_DONE   = 4'h8;
   localparam logic [3:0] IO_STATUS = 4'hC;

   // Status bit indices
   localparam int unsigned ST_BUS = 0;
   localparam int unsigned ST_OVF = 1;

   typedef enum logic [1:0] {RAM, IO, UNMAPPED} region_e;

   // One M-stage bus beat as seen by the responder
   typedef struct packed {
      logic              we;
      logic [DATA_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
   } mem_req_t;

   // Classify a byte address; the I/O window only decodes word-aligned offsets
   function automatic region_e decode_region(input logic [DATA_W-1:0] a,
                                             input logic [27:0]       io_tag,
                                             input logic [DATA_W-1:0] ram_bytes);
      if (a < ram_bytes) return RAM;
      if ((a[31:4] == io_tag) && (a[1:0] == 2'b00)) return IO;
      return UNMAPPED;
   endfunction

endpackage

// File: rtl/dmem_responder_trace_fifo.sv
// Small trace FIFO: wrap-bit pointers, drop-on-full with an overflow pulse.
module trace_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned W     = 32
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         push_i,
   input  logic [W-1:0] push_data_i,
   output logic         full_o,
   input  logic         pop_i,
   output logic         valid_o,
   output logic [W-1:0] data_o,
   output logic         ovf_c
);

   localparam int unsigned IW = $clog2(DEPTH);
   localparam int unsigned PW = IW + 1;

   logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
   logic [W-1:0]  mem_q [DEPTH];
   logic          pop_ok, push_ok;

   // Occupancy flags, handshake qualification and head data
   always_comb begin
      valid_o = (wr_q != rd_q);
      full_o  = (wr_q[IW] != rd_q[IW]) && (wr_q[IW-1:0] == rd_q[IW-1:0]);
      pop_ok  = pop_i && valid_o;
      // A pop in the same cycle frees the slot, so a full FIFO still accepts
      push_ok = push_i && (!full_o || pop_ok);
      ovf_c   = push_i && !push_ok;
      data_o  = valid_o ? mem_q[rd_q[IW-1:0]] : '0;
      wr_d    = wr_q + PW'(push_ok);
      rd_d    = rd_q + PW'(pop_ok);
   end

   // Pointer registers
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         wr_q <= wr_d;
         rd_q <= rd_d;
      end
   end

   // Entry storage; contents are meaningless until pointed at
   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_q[IW-1:0]] <= push_data_i;
   end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder for the MIPS M stage: word RAM plus memory-mapped I/O block.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int unsigned DEPTH       = 64,
   parameter int unsigned TRACE_DEPTH = 4,
   parameter logic [31:0] IO_BASE     = 32'hFFFF_FF00
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        memwrite,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic [31:0] ioout,
   output logic        done,
   output logic        fault,
   output logic        trace_valid,
   input  logic        trace_ready,
   output logic [31:0] trace_data
);

   localparam int unsigned AW        = $clog2(DEPTH);
   localparam logic [27:0] IO_TAG    = IO_BASE[31:4];
   localparam logic [31:0] RAM_BYTES = 32'(DEPTH * 4);

   mem_req_t        req;
   region_e         region;
   logic [AW-1:0]   idx;
   logic [3:0]      off;

   logic [31:0]     mem_q [DEPTH];
   logic [31:0]     cycle_q, ioout_q, exit_q;
   logic            done_q;
   logic [ST_W-1:0] status_q, status_d;

   logic            ram_we, out_we, done_we, status_we, bus_err;
   logic            trace_pop, trace_full, trace_ovf;

   assign req    = '{we: memwrite, addr: addr, wdata: wdata};
   assign region = decode_region(req.addr, IO_TAG, RAM_BYTES);
   assign idx    = req.addr[AW+1:2];
   assign off    = req.addr[3:0];

   // Store decode: route the strobe to one target or flag a bus error
   always_comb begin
      ram_we    = 1'b0;
      out_we    = 1'b0;
      done_we   = 1'b0;
      status_we = 1'b0;
      bus_err   = 1'b0;
      if (req.we && !reset) begin
         unique case (region)
            RAM: begin
               if (req.addr[1:0] == 2'b00) ram_we  = 1'b1;
               else                        bus_err = 1'b1;
            end
            IO: begin
               unique case (off)
                  IO_CYCLE:  ;
                  IO_OUT:    out_we    = 1'b1;
                  IO_DONE:   done_we   = 1'b1;
                  IO_STATUS: status_we = 1'b1;
                  default:   bus_err   = 1'b1;
               endcase
            end
            default: bus_err = 1'b1;
         endcase
      end
   end

   // Load path: zero-latency read of RAM or I/O register, zero elsewhere
   always_comb begin
      rdata = '0;
      unique case (region)
         RAM: rdata = mem_q[idx];
         IO: begin
            unique case (off)
               IO_CYCLE:  rdata = cycle_q;
               IO_OUT:    rdata = ioout_q;
               IO_DONE:   rdata = exit_q;
               IO_STATUS: rdata = {30'b0, status_q};
               default:   rdata = '0;
            endcase
         end
         default: rdata = '0;
      endcase
   end

   // Word RAM; never cleared by reset
   always_ff @(posedge clk) begin
      if (ram_we) mem_q[idx] <= req.wdata;
   end

   // Status next state: a STATUS store clears, events set
   always_comb begin
      status_d = status_q;
      if (status_we) begin
         status_d = '0;
      end else begin
         if (bus_err)   status_d[ST_BUS] = 1'b1;
         if (trace_ovf) status_d[ST_OVF] = 1'b1;
      end
   end

   // I/O registers
   always_ff @(posedge clk) begin
      if (reset) begin
         cycle_q  <= '0;
         ioout_q  <= '0;
         exit_q   <= '0;
         done_q   <= 1'b0;
         status_q <= '0;
      end else begin
         cycle_q  <= cycle_q + 32'd1;
         status_q <= status_d;
         if (out_we) ioout_q <= req.wdata;
         if (done_we) begin
            exit_q <= req.wdata;
            if (req.wdata != '0) done_q <= 1'b1;
         end
      end
   end

   assign trace_pop = trace_valid && trace_ready;

   trace_fifo #(
      .DEPTH (TRACE_DEPTH),
      .W     (32)
   ) u_trace_fifo (
      .clk         (clk),
      .reset       (reset),
      .push_i      (out_we),
      .push_data_i (req.wdata),
      .full_o      (trace_full),
      .pop_i       (trace_pop),
      .valid_o     (trace_valid),
      .data_o      (trace_data),
      .ovf_c       (trace_ovf)
   );

   // An overflow can only be reported against a full FIFO
   ovf_implies_full: assert property (@(posedge clk) disable iff (reset) trace_ovf |-> trace_full);

   assign ioout = ioout_q;
   assign done  = done_q;
   assign fault = |status_q;

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the five-stage pipelined MIPS core: it serves the Memory-stage bus driven by the core (`memwriteM`, `aluoutM` as address, `writedataM` as store data) and returns load data to the core's memory-stage register in the same cycle. Besides a word-addressed RAM, it holds a small memory-mapped I/O block: cycle counter, output port, done/exit register and fault status. Every output-port store is also queued into a trace FIFO that a bench or UART drains over a valid/ready handshake.

## Interface
- `DEPTH`, 64: RAM size in 32-bit words, power of two; `AW = $clog2(DEPTH)`.
- `TRACE_DEPTH`, 4: trace FIFO entries, power of two, ≥2.
- `IO_BASE`, 32'hFFFF_FF00: base of the 16-byte I/O window.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset.
- `memwrite`  in  1  store strobe from the M stage.
- `addr`  in  32  byte address (the core's M-stage ALU result).
- `wdata`  in  32  store data.
- `rdata`  out  32  load data, combinational from `addr`.
- `ioout`  out  32  output-port register.
- `done`  out  1  sticky; set by a store to DONE.
- `fault`  out  1  OR of the status bits.
- `trace_valid`  out  1  FIFO head valid.
- `trace_ready`  in  1  consumer accepts the head.
- `trace_data`  out  32  FIFO head data.

## Operation
- The core has no read strobe. `addr` is decoded every cycle and `rdata` always reflects it.
- RAM region is `addr < DEPTH*4`. Index is `addr[AW+1:2]`. A read ignores `addr[1:0]`. Reads of unmapped space return 0.
- RAM store: written at the clock edge when `memwrite` is high, the address is in range and `addr[1:0]==0`.
- Store fault: a store with `addr[1:0]!=0`, or a store to an address that is neither RAM nor a defined I/O offset, is dropped and sets status bit0 (BUS).
- I/O offsets, decoded when `addr[31:4]==IO_BASE[31:4]` and `addr[1:0]==0`:
  - +0 CYCLE: read-only. Counts clocks since reset and wraps at 2^32. A store to it is ignored and is not a fault.
  - +4 OUT: read/write. A store updates `ioout` and pushes `wdata` into the trace FIFO.
  - +8 DONE: a store latches `wdata` as the exit code and sets `done` if `wdata!=0`. A read returns the exit code. Once set, `done` is cleared only by reset.
  - +C STATUS: a read returns `{30'b0, ovf, bus}`. Any store clears both bits.
- Trace FIFO:
  - A push into a full FIFO drops the data and sets status bit1 (OVF).
  - A push and a pop in the same cycle on a full FIFO is accepted without OVF.
  - A pop occurs when `trace_valid && trace_ready`.
  - Order is FIFO. Pointers are `$clog2(TRACE_DEPTH)+1` bits with a wrap bit.
- Stores after `done` are still performed.
- Reset:
  - CYCLE=0, `ioout`=0, exit code=0, `done`=0, status=0.
  - FIFO empty, so `trace_valid`=0 and `trace_data`=0.
  - RAM is not cleared.
  - `rdata` follows the decode immediately.

## Timing
- Load latency is 0 cycles: `rdata` is combinational from `addr` and the current state.
- Store latency is 1 edge: a read of the same address in the next cycle sees the new value.
- In the same cycle as a store, `rdata` shows the old value.
- CYCLE reads 0 in the first cycle after `reset` falls and reads N in cycle N.
- A store to OUT in cycle t gives `trace_valid=1` in cycle t+1 if the FIFO was empty.
- `trace_data` is stable while `trace_valid && !trace_ready`.
- Status bits are visible on `fault` and on STATUS reads from the cycle after the causing event.
- A fault-causing store and a STATUS clear cannot coincide, because the bus is single-ported.
- A reset asserted mid-operation discards FIFO contents and all I/O state on that edge.

## Structure
- Package `dmem_pkg` holds:
  - I/O offset constants `IO_CYCLE`, `IO_OUT`, `IO_DONE`, `IO_STATUS`.
  - Status bit indices `ST_BUS=0`, `ST_OVF=1`.
  - A `region_e` enum {RAM, IO, UNMAPPED} for the decoder.
- One sub-module, `trace_fifo`, is parameterised by depth and width. It has ports push/full, pop/valid and head data, plus an `ovf` pulse output.
- The decode, RAM, I/O registers and status logic stay in `dmem_responder`.

## Test plan
- RAM store/load: store 32'hDEADBEEF to 0x10, then read 0x10 in the next cycle → `rdata`=DEADBEEF. Reading 0x12 also returns DEADBEEF.
- Misaligned and unmapped stores: store to 0x11 → RAM unchanged, `fault`=1, STATUS reads 1. Store to STATUS → `fault`=0. Store to 0x8000_0000 → `fault`=1.
- CYCLE: release reset, then read IO_BASE+0 in cycle 5 → 5. Preload near wrap (force) → reads FFFF_FFFF then 0.
- Trace FIFO: hold `trace_ready`=0 and store 1..5 to OUT → 4 entries held, `ovf` set, `ioout`=5. Raise ready → `trace_data`=1,2,3,4 on consecutive cycles, then `trace_valid`=0.
- Full FIFO with simultaneous pop and push → no OVF, and the new entry appears last.
- DONE and reset: store 0 to DONE → `done`=0. Store 7 → `done`=1 and a read returns 7. Assert `reset` while FIFO holds 2 entries → all outputs 0 on the next cycle.
